// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS GPIO block:
// register word addresses and edge-type encoding.
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Input synchroniser with previous-sample register
// and per-bit edge pulse generation.
module soc_system_pio_sync
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] in_sync_o,
    output logic [WIDTH-1:0] edge_pulse_o
);

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]       prev_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_vld_q;
    logic [WIDTH-1:0]       rise;
    logic [WIDTH-1:0]       fall;
    logic [WIDTH-1:0]       sel;

    // vld_q[0] is the primed flag; the rest of vld_q follows the
    // first real sample down the chain so reset zeros never look like edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            vld_q      <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            sync_q[0] <= in_port_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q     <= sync_q[SYNC_STAGES-1];
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_vld_q <= vld_q[SYNC_STAGES-1];
        end
    end

    assign in_sync_o = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise = in_sync_o & ~prev_q;
        fall = ~in_sync_o & prev_q;
        if (EDGE_TYPE == int'(EDGE_FALL)) begin
            sel = fall;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            sel = rise | fall;
        end else begin
            sel = rise;
        end
        edge_pulse_o = prev_vld_q ? sel : '0;
    end

endmodule

// File: rtl/soc_system_ctrl_pio.sv
// Avalon-MM GPIO slave: per-bit direction, set/clear outputs,
// edge capture with W1C and a maskable registered interrupt.
module soc_system_ctrl_pio
    import soc_system_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             wr;
    logic             unused_wd;

    assign unused_wd = ^writedata;
    assign wd = writedata[WIDTH-1:0];
    assign wr = chipselect & ~write_n;

    soc_system_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_port_i    (in_port),
        .in_sync_o    (in_sync),
        .edge_pulse_o (edge_pulse)
    );

    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   out_d  = wd;
                ADDR_DIR:    oe_d   = wd;
                ADDR_MASK:   mask_d = wd;
                ADDR_EDGE:   cap_d  = cap_q & ~wd;
                ADDR_OUTSET: out_d  = out_q | wd;
                ADDR_OUTCLR: out_d  = out_q & ~wd;
                default:     ;
            endcase
        end
        // A fresh edge is OR-ed in after the clear so it wins.
        cap_d = cap_d | (edge_pulse & ~oe_q);
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= RESET_VALUE;
            oe_q   <= DIR_RESET;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        case (address)
            ADDR_DATA: rd = (oe_q & out_q) | (~oe_q & in_sync);
            ADDR_DIR:  rd = oe_q;
            ADDR_MASK: rd = mask_q;
            ADDR_EDGE: rd = cap_q;
            default:   rd = '0;
        endcase
        readdata = '0;
        readdata[WIDTH-1:0] = rd;
    end

    assign out_port = out_q;
    assign oe       = oe_q;
    assign irq      = irq_q;

endmodule
